cnn_mac_seq: RTL and testbench

CNN_MAC_SEQ -- requirements
Module: cnn_mac_seq

---
 rtl/cnn_mac_seq.sv | 121 ++++++++++++
 tb/tb_cnn_mac_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_mac_seq.sv
// Sequential 8-bit signed dot-product engine for CNN kernels: fetches weight/pixel
// pairs from a registered-read memory, one MAC every three cycles, optional ReLU.
module cnn_mac_seq #(
  parameter int N_TAPS = 9,
  parameter int W_BASE = 0,
  parameter int X_BASE = 16,
  parameter int ACC_W  = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic                    abort,
  output logic                    mem_cs,
  output logic                    mem_read,
  output logic [32:0]             mem_addr,
  input  logic [7:0]              mem_rdata,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] result
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH_W = 3'd1;
  localparam logic [2:0] FETCH_X = 3'd2;
  localparam logic [2:0] MAC     = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [7:0] LAST_TAP = 8'(N_TAPS - 1);

  logic [2:0]              state;
  logic [7:0]              tap;
  logic signed [ACC_W-1:0] acc;
  logic signed [7:0]       weight;
  logic                    relu_lat;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;

  // Both operands are 8-bit signed, so the 16-bit product cannot overflow.
  assign prod     = weight * $signed(mem_rdata);
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tap      <= '0;
      acc      <= '0;
      weight   <= '0;
      relu_lat <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= FETCH_W;
            tap      <= '0;
            acc      <= '0;
            relu_lat <= relu_en;
          end
        end
        FETCH_W: state <= abort ? IDLE : FETCH_X;
        FETCH_X: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            weight <= $signed(mem_rdata);
            state  <= MAC;
          end
        end
        MAC: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            acc <= acc + prod_ext;
            if (tap == LAST_TAP) begin
              state <= DONE;
            end else begin
              tap   <= tap + 8'd1;
              state <= FETCH_W;
            end
          end
        end
        DONE: begin
          // An abort landing on the done cycle suppresses the result update too.
          if (!abort) begin
            result <= (relu_lat && acc < 0) ? '0 : acc;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_cs   = 1'b0;
    mem_read = 1'b0;
    mem_addr = '0;
    case (state)
      FETCH_W: begin
        mem_cs   = 1'b1;
        mem_read = 1'b1;
        mem_addr = 33'(W_BASE) + 33'(tap);
      end
      FETCH_X: begin
        mem_cs   = 1'b1;
        mem_read = 1'b1;
        mem_addr = 33'(X_BASE) + 33'(tap);
      end
      default: begin
        mem_cs   = 1'b0;
        mem_read = 1'b0;
        mem_addr = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) && !abort;

endmodule

// File: tb/tb_cnn_mac_seq.sv
// Self-checking bench for cnn_mac_seq: table vectors, random data against a
// plain-arithmetic dot-product model, and hand-written abort/reset/start sequences.
module tb_cnn_mac_seq;
  localparam int N      = 9;
  localparam int ACC_W  = 20;
  localparam int W_BASE = 0;
  localparam int X_BASE = 16;
  localparam int LAT    = 3 * N + 1;

  typedef struct {
    int w_val;
    int x_val;
    bit ramp;
    bit relu;
    int exp_res;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic relu_en = 1'b0;
  logic abort = 1'b0;
  logic mem_cs, mem_read, busy, done;
  logic [32:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic signed [ACC_W-1:0] result;

  logic [7:0] mem [0:255];
  int w_arr [N];
  int x_arr [N];
  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read) mem_rdata <= (mem_addr < 33'd256) ? mem[mem_addr[7:0]] : 8'h00;
  end

  cnn_mac_seq #(.N_TAPS(N), .W_BASE(W_BASE), .X_BASE(X_BASE), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .relu_en(relu_en), .abort(abort),
    .mem_cs(mem_cs), .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pattern(input int w, input int x, input bit ramp);
    for (int k = 0; k < N; k++) begin
      w_arr[k] = w;
      x_arr[k] = ramp ? k + 1 : x;
    end
  endtask

  task automatic load_mem();
    for (int k = 0; k < N; k++) begin
      mem[W_BASE + k] = 8'(w_arr[k]);
      mem[X_BASE + k] = 8'(x_arr[k]);
    end
  endtask

  function automatic int model(input bit relu);
    int s = 0;
    for (int k = 0; k < N; k++) s += w_arr[k] * x_arr[k];
    return (relu && s < 0) ? 0 : s;
  endfunction

  // Called at a negedge with the DUT idle; the start pulse is sampled at the next posedge.
  task automatic run_op(input string name, input bit relu, input int exp_res);
    bit seen = 1'b0;
    bit exp_rd;
    int exp_addr;
    load_mem();
    start = 1'b1;
    relu_en = relu;
    @(negedge clk);
    start = 1'b0;
    relu_en = !relu;  // relu_en must only matter at start acceptance
    for (int k = 1; k <= LAT + 10; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= LAT) begin
        exp_rd = (k <= 3 * N) && ((k - 1) % 3 != 2);
        exp_addr = !exp_rd ? 0 : (((k - 1) % 3 == 0) ? W_BASE : X_BASE) + (k - 1) / 3;
        check({name, "_busy"}, busy, 1);
        check({name, "_addr"}, mem_addr, exp_addr);
        check({name, "_read"}, mem_read, exp_rd);
        check({name, "_cs"}, mem_cs, exp_rd);
      end
      if (done) begin
        check({name, "_latency"}, k, LAT);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_done_timeout"}, 0, 1);
    relu_en = 1'b0;
    @(negedge clk);
    check({name, "_result"}, result, exp_res);
    check({name, "_busy_after"}, busy, 0);
  endtask

  // Starts a run and advances to negedge number n of it (n >= 1).
  task automatic run_to(input int n);
    load_mem();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= n; k++) @(negedge clk);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int ndone;
    int lat;
    bit relu;

    vecs[0] = '{w_val: 1,    x_val: 0,    ramp: 1'b1, relu: 1'b0, exp_res: 45};
    vecs[1] = '{w_val: -128, x_val: 127,  ramp: 1'b0, relu: 1'b0, exp_res: -146304};
    vecs[2] = '{w_val: -128, x_val: 127,  ramp: 1'b0, relu: 1'b1, exp_res: 0};
    vecs[3] = '{w_val: 1,    x_val: 0,    ramp: 1'b1, relu: 1'b1, exp_res: 45};
    vecs[4] = '{w_val: -1,   x_val: 0,    ramp: 1'b1, relu: 1'b0, exp_res: -45};
    vecs[5] = '{w_val: -1,   x_val: 0,    ramp: 1'b1, relu: 1'b1, exp_res: 0};
    vecs[6] = '{w_val: 127,  x_val: -128, ramp: 1'b0, relu: 1'b0, exp_res: -146304};
    vecs[7] = '{w_val: -128, x_val: -128, ramp: 1'b0, relu: 1'b0, exp_res: 147456};

    #2 reset_n = 1'b0;
    @(negedge clk);
    check("reset_result", result, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_cs", mem_cs, 0);
    check("reset_read", mem_read, 0);
    check("reset_addr", mem_addr, 0);

    // Start presented together with reset release must be taken on the next edge.
    @(negedge clk);
    reset_n = 1'b1;
    set_pattern(1, 0, 1'b1);
    run_op("post_reset", 1'b0, 45);

    for (int v = 0; v < 8; v++) begin
      set_pattern(vecs[v].w_val, vecs[v].x_val, vecs[v].ramp);
      run_op($sformatf("vec%0d", v), vecs[v].relu, vecs[v].exp_res);
    end

    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < N; k++) begin
        w_arr[k] = int'($urandom_range(0, 255)) - 128;
        x_arr[k] = int'($urandom_range(0, 255)) - 128;
      end
      relu = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", r), relu, model(relu));
    end

    // Second start mid-run is ignored.
    set_pattern(1, 0, 1'b1);
    load_mem();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      start = (k == 5);
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
    end
    start = 1'b0;
    check("restart_latency", lat, LAT);
    check("restart_done_count", ndone, 1);
    check("restart_result", result, 45);

    // Reset mid-run: outputs clear immediately, no done, fresh run works.
    set_pattern(-1, 0, 1'b1);
    run_to(10);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cs", mem_cs, 0);
    check("midrst_read", mem_read, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_done(5, ndone);
    check("midrst_no_done", ndone, 0);
    set_pattern(1, 0, 1'b1);
    run_op("after_midrst", 1'b0, 45);

    // Abort at cycle 12: idle next cycle, no done, result kept.
    set_pattern(-1, 0, 1'b1);
    run_to(12);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    count_done(35, ndone);
    check("abort_no_done", ndone, 0);
    check("abort_result", result, 45);

    // Abort on the done cycle itself suppresses done and the result update.
    run_to(LAT);
    abort = 1'b1;
    #1;
    check("abort_done_cycle_done", done, 0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_cycle_busy", busy, 0);
    check("abort_done_cycle_result", result, 45);

    // Start during the done cycle is ignored.
    set_pattern(2, 0, 1'b1);
    run_to(LAT);
    check("done_cycle_done", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_start_busy", busy, 0);
    check("done_cycle_result", result, 90);
    @(negedge clk);
    check("done_cycle_start_busy2", busy, 0);

    // Abort beats start in the same cycle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
